store_buffer_pq: RTL and testbench

//  Parametrised store buffer between the LSU and the D-cache write port. It replaces the fixed-size store buffer.
//  - Stores allocate speculatively, are committed in order by the ROB and drain in order through a valid/ready port.
//  - Youngest-first byte-granular load forwarding, with partial-overlap detection.
//  - Flush discards uncommitted stores; non-idempotent store tracking for the AGU.

---
 rtl/store_buffer_pq.sv | 157 +++++++++++++++
 tb/tb_store_buffer_pq.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer_pq.sv
// Store buffer between the LSU and the D-cache write port. Stores are allocated
// speculatively, committed in order by the ROB, drained in order, and forward bytes to loads.
module store_buffer_pq #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ROB_TAG_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alloc_valid,
  output logic                  alloc_ready,
  input  logic [XLEN-1:0]       alloc_addr,
  input  logic [XLEN-1:0]       alloc_data,
  input  logic [XLEN/8-1:0]     alloc_mask,
  input  logic [ROB_TAG_W-1:0]  alloc_rob_tag,
  input  logic                  alloc_nonidem,
  input  logic                  commit_valid,
  input  logic [ROB_TAG_W-1:0]  commit_rob_tag,
  output logic                  commit_err,
  input  logic                  flush,
  input  logic [XLEN-1:0]       ld_addr,
  input  logic [XLEN/8-1:0]     ld_mask,
  output logic [XLEN-1:0]       fwd_data,
  output logic [XLEN/8-1:0]     fwd_mask,
  output logic                  fwd_hit,
  output logic                  fwd_partial,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [XLEN-1:0]       mem_req_addr,
  output logic [XLEN-1:0]       mem_req_data,
  output logic [XLEN/8-1:0]     mem_req_mask,
  output logic                  nonidem_exists,
  output logic                  sb_empty
);

  localparam int unsigned MW  = XLEN / 8;
  localparam int unsigned IW  = $clog2(DEPTH);
  localparam int unsigned PW  = IW + 1;
  localparam int unsigned OFS = $clog2(MW);

  typedef struct packed {
    logic [XLEN-1:0]      addr;
    logic [XLEN-1:0]      data;
    logic [MW-1:0]        mask;
    logic [ROB_TAG_W-1:0] tag;
    logic                 nonidem;
  } entry_t;

  logic [PW-1:0]    head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic             commit_err_q, commit_err_d;

  logic             full, alloc_fire, commit_ok, drain;
  logic [PW-1:0]    spec_cnt, occ;
  logic [IW-1:0]    off, fidx;
  logic [MW-1:0]    lane_hit;
  logic [XLEN-1:0]  lane_data;
  logic             unused_ld_lsb;

  assign unused_ld_lsb = ^ld_addr[OFS-1:0];

  always_comb begin
    full          = (tail_q ^ head_q) == {1'b1, {IW{1'b0}}};
    alloc_ready   = !full && !flush;
    alloc_fire    = alloc_valid && alloc_ready;
    commit_ok     = commit_valid && (cmt_q != tail_q) &&
                    (ent_q[cmt_q[IW-1:0]].tag == commit_rob_tag);
    mem_req_valid = head_q != cmt_q;
    drain         = mem_req_valid && mem_req_ready;

    valid_d      = valid_q;
    ent_d        = ent_q;
    head_d       = head_q + PW'(drain);
    cmt_d        = cmt_q + PW'(commit_ok);
    tail_d       = tail_q;
    commit_err_d = commit_valid && !commit_ok;
    off          = '0;
    spec_cnt     = tail_q - cmt_d;

    if (drain) valid_d[head_q[IW-1:0]] = 1'b0;

    // Flush kills exactly the slots in [cmt_d, tail), measured as distance from cmt_d
    if (flush) begin
      tail_d = cmt_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        off = IW'(i) - cmt_d[IW-1:0];
        if ({1'b0, off} < spec_cnt) valid_d[i] = 1'b0;
      end
    end else if (alloc_fire) begin
      ent_d[tail_q[IW-1:0]].addr    = alloc_addr;
      ent_d[tail_q[IW-1:0]].data    = alloc_data;
      ent_d[tail_q[IW-1:0]].mask    = alloc_mask;
      ent_d[tail_q[IW-1:0]].tag     = alloc_rob_tag;
      ent_d[tail_q[IW-1:0]].nonidem = alloc_nonidem;
      valid_d[tail_q[IW-1:0]]       = 1'b1;
      tail_d                        = tail_q + PW'(1);
    end
  end

  always_comb begin
    mem_req_addr = ent_q[head_q[IW-1:0]].addr;
    mem_req_data = ent_q[head_q[IW-1:0]].data;
    mem_req_mask = ent_q[head_q[IW-1:0]].mask;
    commit_err   = commit_err_q;
    sb_empty     = tail_q == head_q;
    nonidem_exists = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (valid_q[i] && ent_q[i].nonidem) nonidem_exists = 1'b1;
  end

  // Oldest-to-youngest walk so a later (younger) match overwrites an older lane
  always_comb begin
    lane_hit  = '0;
    lane_data = '0;
    fidx      = '0;
    occ       = tail_q - head_q;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      fidx = head_q[IW-1:0] + IW'(k);
      if ((PW'(k) < occ) && valid_q[fidx] &&
          (ent_q[fidx].addr[XLEN-1:OFS] == ld_addr[XLEN-1:OFS])) begin
        for (int unsigned b = 0; b < MW; b++) begin
          if (ent_q[fidx].mask[b]) begin
            lane_hit[b]        = 1'b1;
            lane_data[b*8 +: 8] = ent_q[fidx].data[b*8 +: 8];
          end
        end
      end
    end
    fwd_mask = lane_hit & ld_mask;
    fwd_data = '0;
    for (int unsigned b = 0; b < MW; b++)
      if (fwd_mask[b]) fwd_data[b*8 +: 8] = lane_data[b*8 +: 8];
    fwd_hit     = (ld_mask != '0) && ((ld_mask & ~fwd_mask) == '0);
    fwd_partial = (fwd_mask != '0) && !fwd_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q       <= '0;
      cmt_q        <= '0;
      tail_q       <= '0;
      valid_q      <= '0;
      commit_err_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      head_q       <= head_d;
      cmt_q        <= cmt_d;
      tail_q       <= tail_d;
      valid_q      <= valid_d;
      commit_err_q <= commit_err_d;
      for (int unsigned i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

endmodule

// File: tb/tb_store_buffer_pq.sv
// Bench for store_buffer_pq: directed sequences, a forwarding vector table and
// randomized traffic checked against a queue-based reference model.
module tb_store_buffer_pq;

  localparam int XLEN = 32;
  localparam int DEPTH = 8;
  localparam int TW = 5;
  localparam int MW = 4;

  logic            clk, rst_n;
  logic            alloc_valid, alloc_ready, alloc_nonidem;
  logic [XLEN-1:0] alloc_addr, alloc_data;
  logic [MW-1:0]   alloc_mask;
  logic [TW-1:0]   alloc_rob_tag, commit_rob_tag;
  logic            commit_valid, commit_err, flush;
  logic [XLEN-1:0] ld_addr, fwd_data;
  logic [MW-1:0]   ld_mask, fwd_mask;
  logic            fwd_hit, fwd_partial;
  logic            mem_req_valid, mem_req_ready;
  logic [XLEN-1:0] mem_req_addr, mem_req_data;
  logic [MW-1:0]   mem_req_mask;
  logic            nonidem_exists, sb_empty;

  store_buffer_pq #(.XLEN(XLEN), .DEPTH(DEPTH), .ROB_TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_addr(alloc_addr),
    .alloc_data(alloc_data), .alloc_mask(alloc_mask), .alloc_rob_tag(alloc_rob_tag),
    .alloc_nonidem(alloc_nonidem), .commit_valid(commit_valid),
    .commit_rob_tag(commit_rob_tag), .commit_err(commit_err), .flush(flush),
    .ld_addr(ld_addr), .ld_mask(ld_mask), .fwd_data(fwd_data), .fwd_mask(fwd_mask),
    .fwd_hit(fwd_hit), .fwd_partial(fwd_partial), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask),
    .nonidem_exists(nonidem_exists), .sb_empty(sb_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [4:0]  tag;
    logic        ni;
  } ent_t;

  typedef struct {
    logic [31:0] ld_addr;
    logic [3:0]  ld_mask;
    logic [31:0] exp_data;
    logic [3:0]  exp_mask;
    logic        exp_hit;
    logic        exp_partial;
  } fvec_t;

  ent_t q[$];
  int   ncmt;
  logic err_exp;
  int   total, bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_fwd(input logic [31:0] a, input logic [3:0] m,
                           output logic [31:0] d, output logic [3:0] fm,
                           output logic h, output logic p);
    d  = '0;
    fm = '0;
    for (int b = 0; b < 4; b++) begin
      if (m[b]) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
          if (q[i].addr[31:2] == a[31:2] && q[i].mask[b]) begin
            d[b*8 +: 8] = q[i].data[b*8 +: 8];
            fm[b] = 1'b1;
            break;
          end
        end
      end
    end
    h = (m != 0) && ((m & ~fm) == 0);
    p = (fm != 0) && !h;
  endtask

  task automatic model_reset();
    q.delete();
    ncmt    = 0;
    err_exp = 1'b0;
  endtask

  // Inputs are set before calling; compares all outputs with the model, then clocks
  task automatic tick();
    logic [31:0] ed;
    logic [3:0]  em;
    logic        eh, ep, ar, eni, cok, drn;
    #1;
    ar = (q.size() < DEPTH) && !flush;
    eni = 1'b0;
    foreach (q[i]) if (q[i].ni) eni = 1'b1;
    model_fwd(ld_addr, ld_mask, ed, em, eh, ep);
    chk("m_alloc_ready", alloc_ready, ar);
    chk("m_sb_empty", sb_empty, q.size() == 0);
    chk("m_mem_req_valid", mem_req_valid, ncmt > 0);
    if (ncmt > 0) begin
      chk("m_mem_req_addr", mem_req_addr, q[0].addr);
      chk("m_mem_req_data", mem_req_data, q[0].data);
      chk("m_mem_req_mask", mem_req_mask, q[0].mask);
    end
    chk("m_commit_err", commit_err, err_exp);
    chk("m_nonidem", nonidem_exists, eni);
    chk("m_fwd_data", fwd_data, ed);
    chk("m_fwd_mask", fwd_mask, em);
    chk("m_fwd_hit", fwd_hit, eh);
    chk("m_fwd_partial", fwd_partial, ep);
    @(posedge clk);
    cok = commit_valid && (q.size() > ncmt) && (q[ncmt].tag == commit_rob_tag);
    drn = (ncmt > 0) && mem_req_ready;
    err_exp = commit_valid && !cok;
    if (drn) begin
      void'(q.pop_front());
      ncmt--;
    end
    if (cok) ncmt++;
    if (flush) begin
      while (q.size() > ncmt) void'(q.pop_back());
    end else if (alloc_valid && ar) begin
      q.push_back('{alloc_addr, alloc_data, alloc_mask, alloc_rob_tag, alloc_nonidem});
    end
    #1;
  endtask

  task automatic set_idle();
    alloc_valid = 0; alloc_addr = 0; alloc_data = 0; alloc_mask = 0;
    alloc_rob_tag = 0; alloc_nonidem = 0; commit_valid = 0; commit_rob_tag = 0;
    flush = 0; ld_addr = 0; ld_mask = 0; mem_req_ready = 0;
  endtask

  task automatic do_alloc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                          input logic [4:0] t, input logic ni);
    alloc_valid = 1; alloc_addr = a; alloc_data = d; alloc_mask = m;
    alloc_rob_tag = t; alloc_nonidem = ni;
    tick();
    alloc_valid = 0; alloc_nonidem = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    fvec_t       vecs[7];
    logic [31:0] got[8];
    int          nd;

    total = 0;
    bad = 0;
    set_idle();
    model_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_sb_empty", sb_empty, 1);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_nonidem", nonidem_exists, 0);
    chk("rst_commit_err", commit_err, 0);
    rst_n = 1;

    for (int i = 0; i < 8; i++) do_alloc(32'h1000 + i * 4, i * 32'h01010101, 4'hF, 5'(i), 0);
    chk("full_alloc_ready", alloc_ready, 0);
    nd = 0;
    for (int c = 0; c < 40 && nd < 8; c++) begin
      commit_valid = (c < 8);
      commit_rob_tag = 5'(c);
      mem_req_ready = 1;
      #1;
      if (mem_req_valid) begin
        got[nd] = mem_req_addr;
        nd++;
      end
      tick();
    end
    set_idle();
    chk("drain_count", nd, 8);
    for (int i = 0; i < 8; i++) chk("drain_order", got[i], 32'h1000 + i * 4);
    #1;
    chk("drained_empty", sb_empty, 1);

    vecs[0] = '{32'h100, 4'hF, 32'h1122AA44, 4'hF, 1, 0};
    vecs[1] = '{32'h200, 4'hF, 32'h00007788, 4'h3, 0, 1};
    vecs[2] = '{32'h200, 4'h3, 32'h00007788, 4'h3, 1, 0};
    vecs[3] = '{32'h300, 4'hF, 32'h00000000, 4'h0, 0, 0};
    vecs[4] = '{32'h100, 4'h0, 32'h00000000, 4'h0, 0, 0};
    vecs[5] = '{32'h102, 4'h2, 32'h0000AA00, 4'h2, 1, 0};
    vecs[6] = '{32'h200, 4'h4, 32'h00000000, 4'h0, 0, 0};
    do_alloc(32'h100, 32'h11223344, 4'hF, 5'd10, 0);
    do_alloc(32'h100, 32'h0000AA00, 4'h2, 5'd11, 0);
    do_alloc(32'h200, 32'h55667788, 4'h3, 5'd12, 0);
    for (int i = 0; i < 7; i++) begin
      ld_addr = vecs[i].ld_addr;
      ld_mask = vecs[i].ld_mask;
      #1;
      chk("vec_fwd_data", fwd_data, vecs[i].exp_data);
      chk("vec_fwd_mask", fwd_mask, vecs[i].exp_mask);
      chk("vec_fwd_hit", fwd_hit, vecs[i].exp_hit);
      chk("vec_fwd_partial", fwd_partial, vecs[i].exp_partial);
      tick();
    end
    set_idle();
    flush = 1;
    tick();
    flush = 0;
    #1;
    chk("flush_empty", sb_empty, 1);

    do_alloc(32'h300, 32'hA3A3A3A3, 4'hF, 5'd3, 0);
    do_alloc(32'h304, 32'hA4A4A4A4, 4'hF, 5'd4, 0);
    do_alloc(32'h308, 32'hA5A5A5A5, 4'hF, 5'd5, 0);
    commit_valid = 1; commit_rob_tag = 5'd3; flush = 1;
    tick();
    commit_valid = 0; flush = 0; mem_req_ready = 1;
    #1;
    chk("cf_mem_valid", mem_req_valid, 1);
    chk("cf_mem_addr", mem_req_addr, 32'h300);
    tick();
    mem_req_ready = 0;
    #1;
    chk("cf_empty", sb_empty, 1);
    commit_valid = 1; commit_rob_tag = 5'd9;
    tick();
    commit_valid = 0;
    #1;
    chk("cerr_pulse", commit_err, 1);
    tick();
    #1;
    chk("cerr_clear", commit_err, 0);

    do_alloc(32'h400, 32'hDEADBEEF, 4'hF, 5'd7, 1);
    #1;
    chk("ni_set", nonidem_exists, 1);
    commit_valid = 1; commit_rob_tag = 5'd7;
    tick();
    commit_valid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_valid", mem_req_valid, 1);
      chk("hold_addr", mem_req_addr, 32'h400);
      chk("hold_data", mem_req_data, 32'hDEADBEEF);
      chk("hold_mask", mem_req_mask, 4'hF);
      tick();
    end
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    #1;
    chk("ni_clear", nonidem_exists, 0);

    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        rst_n = 0;
        #1;
        chk("midrst_empty", sb_empty, 1);
        chk("midrst_mem_valid", mem_req_valid, 0);
        rst_n = 1;
        model_reset();
      end
      alloc_valid    = ($urandom % 2) == 0;
      alloc_addr     = 32'h100 + ($urandom % 4) * 4 + ($urandom % 4);
      alloc_data     = $urandom;
      alloc_mask     = 4'($urandom);
      alloc_rob_tag  = 5'($urandom);
      alloc_nonidem  = ($urandom % 8) == 0;
      commit_valid   = ($urandom % 3) == 0;
      commit_rob_tag = (q.size() > ncmt && ($urandom % 4) != 0) ? q[ncmt].tag : 5'($urandom);
      flush          = ($urandom % 20) == 0;
      ld_addr        = 32'h100 + ($urandom % 5) * 4 + ($urandom % 4);
      ld_mask        = 4'($urandom);
      mem_req_ready  = ($urandom % 2) == 0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
